// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter that shares the VGA adapter's single pixel-write port
// between NUM_REQ pixel-stream requesters. Grants lock for a burst, capped at
// MAX_BURST pixels whenever someone else is waiting. Outputs are registered.
module vga_plot_arbiter #(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned MAX_BURST = 64,
  parameter int unsigned X_W       = 8,
  parameter int unsigned Y_W       = 7,
  parameter int unsigned C_W       = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     pix_valid,
  input  logic [NUM_REQ-1:0]     pix_last,
  input  logic [NUM_REQ*X_W-1:0] x_in,
  input  logic [NUM_REQ*Y_W-1:0] y_in,
  input  logic [NUM_REQ*C_W-1:0] colour_in,
  output logic [NUM_REQ-1:0]     grant,
  output logic [2:0]             owner,
  output logic                   busy,
  output logic [X_W-1:0]         vga_x,
  output logic [Y_W-1:0]         vga_y,
  output logic [C_W-1:0]         colour,
  output logic                   plot
);

  localparam int unsigned CntW = $clog2(MAX_BURST) + 1;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [2:0]           owner_q, owner_d;
  logic [2:0]           rr_last_q, rr_last_d;
  logic [CntW-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [X_W-1:0]       x_q, x_d;
  logic [Y_W-1:0]       y_q, y_d;
  logic [C_W-1:0]       c_q, c_d;
  logic                 plot_q, plot_d;

  logic                 sel_req, sel_valid, sel_last;
  logic [X_W-1:0]       sel_x;
  logic [Y_W-1:0]       sel_y;
  logic [C_W-1:0]       sel_c;
  logic [2:0]           winner;
  logic [NUM_REQ-1:0]   winner_oh;
  logic                 found;
  logic                 others_pending;

  // Mux out the current owner's request and pixel slice.
  always_comb begin
    sel_req   = 1'b0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_x     = '0;
    sel_y     = '0;
    sel_c     = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (owner_q == 3'(j)) begin
        sel_req   = req[j];
        sel_valid = pix_valid[j];
        sel_last  = pix_last[j];
        sel_x     = x_in[j*X_W +: X_W];
        sel_y     = y_in[j*Y_W +: Y_W];
        sel_c     = colour_in[j*C_W +: C_W];
      end
    end
  end

  // Round-robin search upward from rr_last+1; the last owner is checked last.
  always_comb begin
    found     = 1'b0;
    winner    = '0;
    winner_oh = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!found && req[j] && (((32'(rr_last_q) + k) % NUM_REQ) == j)) begin
          found        = 1'b1;
          winner       = 3'(j);
          winner_oh[j] = 1'b1;
        end
      end
    end
  end

  // Saturating burst count and whether anyone besides the owner is asking.
  always_comb begin
    cnt_inc        = (cnt_q == CntW'(MAX_BURST)) ? cnt_q : cnt_q + CntW'(1);
    others_pending = |(req & ~grant_q);
  end

  // Next-state: arbitration in idle, pixel acceptance and release in busy.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    y_d       = y_q;
    c_d       = c_q;
    plot_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          owner_d = winner;
          grant_d = winner_oh;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (!sel_req) begin
          // Request withdrawn: nothing accepted this cycle.
          grant_d   = '0;
          rr_last_d = owner_q;
          state_d   = StIdle;
        end else if (sel_valid) begin
          plot_d = 1'b1;
          x_d    = sel_x;
          y_d    = sel_y;
          c_d    = sel_c;
          cnt_d  = cnt_inc;
          if (sel_last || ((cnt_inc == CntW'(MAX_BURST)) && others_pending)) begin
            grant_d   = '0;
            rr_last_d = owner_q;
            state_d   = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset clears every output immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      owner_q   <= '0;
      rr_last_q <= 3'(NUM_REQ - 1);
      cnt_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      c_q       <= '0;
      plot_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      c_q       <= c_d;
      plot_q    <= plot_d;
    end
  end

  assign grant  = grant_q;
  assign owner  = owner_q;
  assign busy   = |grant_q;
  assign vga_x  = x_q;
  assign vga_y  = y_q;
  assign colour = c_q;
  assign plot   = plot_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter (3 requesters, MAX_BURST = 4).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_vga_plot_arbiter;

  localparam int unsigned NR = 3;
  localparam int unsigned MB = 4;
  localparam int unsigned XW = 8;
  localparam int unsigned YW = 7;
  localparam int unsigned CW = 3;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [NR-1:0]   req, pix_valid, pix_last;
  logic [XW-1:0]   tx [NR];
  logic [YW-1:0]   ty [NR];
  logic [CW-1:0]   tc [NR];
  logic [NR*XW-1:0] x_in;
  logic [NR*YW-1:0] y_in;
  logic [NR*CW-1:0] colour_in;
  logic [NR-1:0]   grant;
  logic [2:0]      owner;
  logic            busy;
  logic [XW-1:0]   vga_x;
  logic [YW-1:0]   vga_y;
  logic [CW-1:0]   colour;
  logic            plot;

  int passed = 0;
  int total  = 0;

  assign x_in      = {tx[2], tx[1], tx[0]};
  assign y_in      = {ty[2], ty[1], ty[0]};
  assign colour_in = {tc[2], tc[1], tc[0]};

  vga_plot_arbiter #(
    .NUM_REQ  (NR),
    .MAX_BURST(MB),
    .X_W      (XW),
    .Y_W      (YW),
    .C_W      (CW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .pix_valid(pix_valid),
    .pix_last (pix_last),
    .x_in     (x_in),
    .y_in     (y_in),
    .colour_in(colour_in),
    .grant    (grant),
    .owner    (owner),
    .busy     (busy),
    .vga_x    (vga_x),
    .vga_y    (vga_y),
    .colour   (colour),
    .plot     (plot)
  );

  always #10 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    req       = '0;
    pix_valid = '0;
    pix_last  = '0;
    for (int i = 0; i < int'(NR); i++) begin
      tx[i] = '0;
      ty[i] = '0;
      tc[i] = '0;
    end
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    req   = 3'b111;
    reset = 1'b1;
    step();
    total++;
    if ({grant, owner, busy, vga_x, vga_y, colour, plot} !== 26'd0) begin
      $display("FAIL reset_outputs: got %h want 0",
               {grant, owner, busy, vga_x, vga_y, colour, plot});
    end else passed++;
    reset = 1'b0;
    step();
    total++;
    if ({grant, owner} !== {3'b001, 3'd0}) begin
      $display("FAIL reset_first_winner: got %h want %h", {grant, owner}, {3'b001, 3'd0});
    end else passed++;
  endtask

  task automatic test_single();
    apply_reset();
    req[0] = 1'b1; pix_valid[0] = 1'b1; tx[0] = 8'd10; ty[0] = 7'd5; tc[0] = 3'b100;
    step();
    total++;
    if ({grant, busy, owner, plot} !== {3'b001, 1'b1, 3'd0, 1'b0}) begin
      $display("FAIL single_grant: got %h want %h", {grant, busy, owner, plot},
               {3'b001, 1'b1, 3'd0, 1'b0});
    end else passed++;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if ({grant, plot, vga_x, vga_y, colour} !==
          {(k == 3) ? 3'b000 : 3'b001, 1'b1, 8'(10 + k), 7'd5, 3'b100}) begin
        $display("FAIL single_px%0d: got %h want %h", k, {grant, plot, vga_x, vga_y, colour},
                 {(k == 3) ? 3'b000 : 3'b001, 1'b1, 8'(10 + k), 7'd5, 3'b100});
      end else passed++;
      tx[0] = 8'(11 + k);
      if (k == 2) pix_last[0] = 1'b1;
    end
    // Last owner was 0, so requester 1 wins a simultaneous request.
    clear_inputs();
    req = 3'b011;
    step();
    total++;
    if ({grant, owner, plot} !== {3'b010, 3'd1, 1'b0}) begin
      $display("FAIL single_rr_after: got %h want %h", {grant, owner, plot}, {3'b010, 3'd1, 1'b0});
    end else passed++;
  endtask

  task automatic test_two_req();
    apply_reset();
    req = 3'b011; pix_valid = 3'b011;
    tx[0] = 8'd20; ty[0] = 7'd1; tc[0] = 3'd1;
    tx[1] = 8'd30; ty[1] = 7'd2; tc[1] = 3'd2;
    step();
    total++;
    if ({grant, owner} !== {3'b001, 3'd0}) begin
      $display("FAIL two_first: got %h want %h", {grant, owner}, {3'b001, 3'd0});
    end else passed++;
    step();
    total++;
    if ({grant, plot, vga_x} !== {3'b001, 1'b1, 8'd20}) begin
      $display("FAIL two_r0_px0: got %h want %h", {grant, plot, vga_x}, {3'b001, 1'b1, 8'd20});
    end else passed++;
    tx[0] = 8'd21; pix_last[0] = 1'b1;
    step();
    total++;
    if ({grant, plot, vga_x, owner} !== {3'b000, 1'b1, 8'd21, 3'd0}) begin
      $display("FAIL two_r0_px1: got %h want %h", {grant, plot, vga_x, owner},
               {3'b000, 1'b1, 8'd21, 3'd0});
    end else passed++;
    req[0] = 1'b0; pix_valid[0] = 1'b0; pix_last[0] = 1'b0;
    step();
    total++;
    if ({grant, owner, plot} !== {3'b010, 3'd1, 1'b0}) begin
      $display("FAIL two_second: got %h want %h", {grant, owner, plot}, {3'b010, 3'd1, 1'b0});
    end else passed++;
    step();
    total++;
    if ({grant, plot, vga_x, vga_y, colour} !== {3'b010, 1'b1, 8'd30, 7'd2, 3'd2}) begin
      $display("FAIL two_r1_px0: got %h want %h", {grant, plot, vga_x, vga_y, colour},
               {3'b010, 1'b1, 8'd30, 7'd2, 3'd2});
    end else passed++;
    tx[1] = 8'd31; pix_last[1] = 1'b1;
    step();
    total++;
    if ({grant, plot, vga_x, owner} !== {3'b000, 1'b1, 8'd31, 3'd1}) begin
      $display("FAIL two_r1_px1: got %h want %h", {grant, plot, vga_x, owner},
               {3'b000, 1'b1, 8'd31, 3'd1});
    end else passed++;
  endtask

  task automatic test_burst_preempt();
    apply_reset();
    req[2] = 1'b1; pix_valid[2] = 1'b1; tx[2] = 8'd50; ty[2] = 7'd7; tc[2] = 3'd5;
    step();
    total++;
    if ({grant, owner} !== {3'b100, 3'd2}) begin
      $display("FAIL pre_grant2: got %h want %h", {grant, owner}, {3'b100, 3'd2});
    end else passed++;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if ({grant, plot, vga_x} !== {(k == 3) ? 3'b000 : 3'b100, 1'b1, 8'(50 + k)}) begin
        $display("FAIL pre_a_px%0d: got %h want %h", k, {grant, plot, vga_x},
                 {(k == 3) ? 3'b000 : 3'b100, 1'b1, 8'(50 + k)});
      end else passed++;
      tx[2] = 8'(51 + k);
      if (k == 1) begin
        req[0] = 1'b1; pix_valid[0] = 1'b1; pix_last[0] = 1'b1;
        tx[0] = 8'd70; ty[0] = 7'd0; tc[0] = 3'd6;
      end
    end
    step();
    total++;
    if ({grant, owner, plot} !== {3'b001, 3'd0, 1'b0}) begin
      $display("FAIL pre_grant0: got %h want %h", {grant, owner, plot}, {3'b001, 3'd0, 1'b0});
    end else passed++;
    step();
    total++;
    if ({grant, plot, vga_x, colour} !== {3'b000, 1'b1, 8'd70, 3'd6}) begin
      $display("FAIL pre_r0_px: got %h want %h", {grant, plot, vga_x, colour},
               {3'b000, 1'b1, 8'd70, 3'd6});
    end else passed++;
    req[0] = 1'b0; pix_valid[0] = 1'b0; pix_last[0] = 1'b0;
    step();
    total++;
    if ({grant, owner, plot} !== {3'b100, 3'd2, 1'b0}) begin
      $display("FAIL pre_regrant2: got %h want %h", {grant, owner, plot}, {3'b100, 3'd2, 1'b0});
    end else passed++;
    for (int k = 0; k < 6; k++) begin
      step();
      total++;
      if ({grant, plot, vga_x} !== {(k == 5) ? 3'b000 : 3'b100, 1'b1, 8'(54 + k)}) begin
        $display("FAIL pre_b_px%0d: got %h want %h", k, {grant, plot, vga_x},
                 {(k == 5) ? 3'b000 : 3'b100, 1'b1, 8'(54 + k)});
      end else passed++;
      tx[2] = 8'(55 + k);
      if (k == 4) pix_last[2] = 1'b1;
    end
  endtask

  task automatic test_burst_no_compete();
    apply_reset();
    req[2] = 1'b1; pix_valid[2] = 1'b1; tx[2] = 8'd50; ty[2] = 7'd9; tc[2] = 3'd7;
    step();
    total++;
    if ({grant, owner} !== {3'b100, 3'd2}) begin
      $display("FAIL solo_grant: got %h want %h", {grant, owner}, {3'b100, 3'd2});
    end else passed++;
    for (int k = 0; k < 10; k++) begin
      step();
      total++;
      if ({grant, plot, vga_x} !== {(k == 9) ? 3'b000 : 3'b100, 1'b1, 8'(50 + k)}) begin
        $display("FAIL solo_px%0d: got %h want %h", k, {grant, plot, vga_x},
                 {(k == 9) ? 3'b000 : 3'b100, 1'b1, 8'(50 + k)});
      end else passed++;
      tx[2] = 8'(51 + k);
      if (k == 8) pix_last[2] = 1'b1;
    end
  endtask

  task automatic test_valid_gaps();
    apply_reset();
    req[0] = 1'b1; pix_valid[0] = 1'b1; tx[0] = 8'd80; ty[0] = 7'd3; tc[0] = 3'd2;
    step();
    step();
    total++;
    if ({grant, plot, vga_x} !== {3'b001, 1'b1, 8'd80}) begin
      $display("FAIL gap_p0: got %h want %h", {grant, plot, vga_x}, {3'b001, 1'b1, 8'd80});
    end else passed++;
    pix_valid[0] = 1'b0; tx[0] = 8'd81;
    step();
    total++;
    if ({grant, plot, vga_x} !== {3'b001, 1'b0, 8'd80}) begin
      $display("FAIL gap_p1: got %h want %h", {grant, plot, vga_x}, {3'b001, 1'b0, 8'd80});
    end else passed++;
    step();
    total++;
    if ({grant, plot, vga_x} !== {3'b001, 1'b0, 8'd80}) begin
      $display("FAIL gap_p2: got %h want %h", {grant, plot, vga_x}, {3'b001, 1'b0, 8'd80});
    end else passed++;
    pix_valid[0] = 1'b1; pix_last[0] = 1'b1;
    step();
    total++;
    if ({grant, plot, vga_x} !== {3'b000, 1'b1, 8'd81}) begin
      $display("FAIL gap_p3: got %h want %h", {grant, plot, vga_x}, {3'b000, 1'b1, 8'd81});
    end else passed++;
  endtask

  task automatic test_req_drop();
    apply_reset();
    req[1] = 1'b1; pix_valid[1] = 1'b1; tx[1] = 8'd5;
    step();
    total++;
    if ({grant, owner} !== {3'b010, 3'd1}) begin
      $display("FAIL drop_grant: got %h want %h", {grant, owner}, {3'b010, 3'd1});
    end else passed++;
    req[1] = 1'b0;
    step();
    total++;
    if ({grant, busy, plot, owner} !== {3'b000, 1'b0, 1'b0, 3'd1}) begin
      $display("FAIL drop_release: got %h want %h", {grant, busy, plot, owner},
               {3'b000, 1'b0, 1'b0, 3'd1});
    end else passed++;
    req = 3'b110;
    step();
    total++;
    if ({grant, owner} !== {3'b100, 3'd2}) begin
      $display("FAIL drop_rr: got %h want %h", {grant, owner}, {3'b100, 3'd2});
    end else passed++;
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    req[0] = 1'b1; pix_valid[0] = 1'b1; tx[0] = 8'd90;
    step();
    step();
    tx[0] = 8'd91;
    step();
    total++;
    if ({grant, plot, vga_x} !== {3'b001, 1'b1, 8'd91}) begin
      $display("FAIL mid_before: got %h want %h", {grant, plot, vga_x}, {3'b001, 1'b1, 8'd91});
    end else passed++;
    tx[0] = 8'd92;
    req[1] = 1'b1; pix_valid[1] = 1'b1; tx[1] = 8'd40;
    reset = 1'b1;
    #1;
    total++;
    if ({grant, plot, vga_x, busy} !== 13'd0) begin
      $display("FAIL mid_reset_clear: got %h want 0", {grant, plot, vga_x, busy});
    end else passed++;
    #2;
    reset = 1'b0;
    tx[0] = 8'd90;
    step();
    total++;
    if ({grant, owner} !== {3'b001, 3'd0}) begin
      $display("FAIL mid_regrant: got %h want %h", {grant, owner}, {3'b001, 3'd0});
    end else passed++;
    step();
    total++;
    if ({plot, vga_x} !== {1'b1, 8'd90}) begin
      $display("FAIL mid_restart_px: got %h want %h", {plot, vga_x}, {1'b1, 8'd90});
    end else passed++;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_two_req();
    test_burst_preempt();
    test_burst_no_compete();
    test_valid_gaps();
    test_req_drop();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
